// File: rtl/sta_lta_detector.sv
// STA/LTA event detector.
// Keeps running short- and long-window sums from the delay-buffer taps and compares
// the two averages against on/off ratio thresholds. A trigger FSM with hold-off turns
// threshold crossings into events, and each completed event goes to the logger over a
// valid/ack handshake.
// Pipeline: taps -> sums (1 clk) -> products (2 clk) -> state/triggerPulse (3 clk).
module sta_lta_detector #(
  parameter int          SHORT_N   = 16,
  parameter int          LONG_N    = 32,
  parameter int          SUM_W     = 21,
  parameter logic [7:0]  ON_RATIO  = 8'h30,
  parameter logic [7:0]  OFF_RATIO = 8'h18,
  parameter int          MIN_LEVEL = 256,
  parameter int          HOLDOFF   = 64,
  parameter int          MAX_EVENT = 4096
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      firstShort,
  input  logic [15:0]      lastShort,
  input  logic [15:0]      firstLong,
  input  logic [15:0]      lastLong,
  input  logic             initDone,
  output logic             triggerPulse,
  output logic             active,
  output logic             eventValid,
  input  logic             eventAck,
  output logic [31:0]      eventTime,
  output logic [15:0]      eventLength,
  output logic [SUM_W-1:0] eventPeak,
  output logic             overflow
);
  // Product width: all scale factors fit in 16 bits, so no truncation is needed.
  localparam int PW    = SUM_W + 16;
  localparam int STA_K = LONG_N * 16;
  localparam int ON_K  = SHORT_N * int'(ON_RATIO);
  localparam int OFF_K = SHORT_N * int'(OFF_RATIO);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, HOLD} state_t;

  state_t           state;
  logic [SUM_W-1:0] shortSum, longSum, shortSum_d, peak, peakNext;
  logic [31:0]      sampleCount, curTime;
  logic [PW-1:0]    staP, ltaOn, ltaOff;
  logic [15:0]      len, hcnt;
  logic             onCond, offCond;

  // Stage 1: running window sums (mod 2^SUM_W) and free-running sample counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shortSum    <= '0;
      longSum     <= '0;
      sampleCount <= '0;
    end else begin
      shortSum    <= shortSum + SUM_W'(firstShort) - SUM_W'(lastShort);
      longSum     <= longSum + SUM_W'(firstLong) - SUM_W'(lastLong);
      sampleCount <= sampleCount + 32'd1;
    end
  end

  // Stage 2: cross-multiplied ratio terms so the compare needs no divider.
  // STA/LTA > R  <=>  shortSum*LONG_N*16 > longSum*SHORT_N*R  (R in Q4.4).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      staP       <= '0;
      ltaOn      <= '0;
      ltaOff     <= '0;
      shortSum_d <= '0;
    end else begin
      staP       <= PW'(shortSum) * PW'(STA_K);
      ltaOn      <= PW'(longSum) * PW'(ON_K);
      ltaOff     <= PW'(longSum) * PW'(OFF_K);
      shortSum_d <= shortSum;
    end
  end

  assign onCond   = (staP > ltaOn) && (shortSum_d >= SUM_W'(MIN_LEVEL));
  assign offCond  = staP < ltaOff;
  assign peakNext = (shortSum_d > peak) ? shortSum_d : peak;

  // Stage 3: trigger FSM plus the event record handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      triggerPulse <= 1'b0;
      active       <= 1'b0;
      eventValid   <= 1'b0;
      eventTime    <= '0;
      eventLength  <= '0;
      eventPeak    <= '0;
      overflow     <= 1'b0;
      curTime      <= '0;
      len          <= '0;
      hcnt         <= '0;
      peak         <= '0;
    end else begin
      triggerPulse <= 1'b0;
      // An ack retires the record; a record issued this same clock overrides below.
      if (eventValid && eventAck) eventValid <= 1'b0;
      if (!initDone) begin
        // Buffer not valid: drop any event in flight without a record.
        state  <= IDLE;
        active <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARMED;
          ARMED: if (onCond) begin
            state        <= ACTIVE;
            active       <= 1'b1;
            triggerPulse <= 1'b1;
            curTime      <= sampleCount;
            len          <= '0;
            peak         <= shortSum_d;
          end
          ACTIVE: begin
            len  <= (len == 16'hFFFF) ? len : len + 16'd1;
            peak <= peakNext;
            if (offCond || len == 16'(MAX_EVENT - 1)) begin
              state  <= HOLD;
              active <= 1'b0;
              hcnt   <= '0;
              if (!eventValid || eventAck) begin
                eventValid  <= 1'b1;
                eventTime   <= curTime;
                eventLength <= len;
                eventPeak   <= peakNext;
              end else begin
                // Logger still holds the previous record: keep it, flag the loss.
                overflow <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (hcnt == 16'(HOLDOFF - 1)) state <= ARMED;
            else hcnt <= hcnt + 16'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sta_lta_detector.sv
// Directed bench for sta_lta_detector: expected trigger clocks and event records are
// queued when stimulus is applied and compared when the DUT produces them.
module tb_sta_lta_detector;
  localparam int SUM_W = 21;

  logic             clock = 1'b0;
  logic             reset;
  logic [15:0]      firstShort, lastShort, firstLong, lastLong;
  logic             initDone, eventAck;
  logic             triggerPulse, active, eventValid, overflow;
  logic [31:0]      eventTime;
  logic [15:0]      eventLength;
  logic [SUM_W-1:0] eventPeak;

  typedef struct packed {
    logic [31:0]      t;
    logic [15:0]      len;
    logic [SUM_W-1:0] pk;
  } rec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   e0, e1, k;
  int   pulse_q[$];
  rec_t rec_q[$];

  always #5 clock = ~clock;

  sta_lta_detector #(.SUM_W(SUM_W)) dut (
    .clock(clock), .reset(reset),
    .firstShort(firstShort), .lastShort(lastShort),
    .firstLong(firstLong), .lastLong(lastLong),
    .initDone(initDone), .triggerPulse(triggerPulse), .active(active),
    .eventValid(eventValid), .eventAck(eventAck), .eventTime(eventTime),
    .eventLength(eventLength), .eventPeak(eventPeak), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; cyc counts edges since reset release, so the DUT's sampleCount
  // before edge cyc is cyc-1. triggerPulse must be high exactly on queued clocks.
  task automatic tick();
    @(posedge clock); #1;
    cyc++;
    if (pulse_q.size() != 0 && pulse_q[0] == cyc) begin
      chk("pulse", 64'(triggerPulse), 64'd1);
      void'(pulse_q.pop_front());
    end else begin
      chk("no_pulse", 64'(triggerPulse), 64'd0);
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  // Compare the presented record with the head of the scoreboard.
  task automatic check_rec(input string tag);
    rec_t r;
    if (rec_q.size() == 0) begin
      chk({tag, "_queue"}, 64'(rec_q.size()), 64'd1);
    end else begin
      r = rec_q[0];
      chk({tag, "_valid"}, 64'(eventValid), 64'd1);
      chk({tag, "_time"}, 64'(eventTime), 64'(r.t));
      chk({tag, "_len"}, 64'(eventLength), 64'(r.len));
      chk({tag, "_peak"}, 64'(eventPeak), 64'(r.pk));
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pulse"}, 64'(triggerPulse), 64'd0);
    chk({tag, "_active"}, 64'(active), 64'd0);
    chk({tag, "_valid"}, 64'(eventValid), 64'd0);
    chk({tag, "_time"}, 64'(eventTime), 64'd0);
    chk({tag, "_len"}, 64'(eventLength), 64'd0);
    chk({tag, "_peak"}, 64'(eventPeak), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    reset = 1'b0; initDone = 1'b0; eventAck = 1'b0;
    firstShort = '0; lastShort = '0; firstLong = '0; lastLong = '0;
    #12;
    chk_outputs_zero("rst_state");
    @(posedge clock); #1;
    reset = 1'b1; cyc = 0;

    // Equal taps in and out: sums never move, nothing triggers.
    initDone = 1'b1;
    firstShort = 16'd500; lastShort = 16'd500; firstLong = 16'd500; lastLong = 16'd500;
    repeat (1000) tick();
    chk("flat_short", 64'(dut.shortSum), 64'd0);
    chk("flat_long", 64'(dut.longSum), 64'd0);
    chk("flat_active", 64'(active), 64'd0);
    firstShort = '0; lastShort = '0; firstLong = '0; lastLong = '0;

    // Preload longSum = 32*100 = 3200. Trigger needs shortSum*512 > 3200*768,
    // i.e. shortSum > 4800: reached after the 5th sample of 1000.
    firstLong = 16'd100;
    repeat (32) tick();
    firstLong = '0;
    chk("preload_long", 64'(dut.longSum), 64'd3200);

    // Samples enter on edges e0+1..; sum=5000 at e0+5, product e0+6, pulse e0+7.
    e0 = cyc;
    firstShort = 16'd1000;
    pulse_q.push_back(e0 + 7);
    // Off when shortSum*512 < 3200*384, i.e. shortSum <= 2000: sum reaches 2000 at
    // e0+30 on the way down, exit at e0+32. len counts edges e0+8..e0+31 = 24.
    rec_q.push_back(rec_t'{t: 32'(e0 + 6), len: 16'd24, pk: SUM_W'(16000)});
    run_to(e0 + 8);
    chk("ev1_active", 64'(active), 64'd1);
    run_to(e0 + 16);
    firstShort = '0; lastShort = 16'd1000;
    run_to(e0 + 31);
    chk("ev1_still_active", 64'(active), 64'd1);
    chk("ev1_not_valid_yet", 64'(eventValid), 64'd0);
    run_to(e0 + 32);
    lastShort = '0;
    chk("ev1_ended", 64'(active), 64'd0);
    check_rec("ev1_rec");

    // Retrigger level (10000) during hold-off: ARMED again at e0+96, pulse at e0+97.
    firstShort = 16'd1000;
    run_to(e0 + 42);
    firstShort = '0;
    pulse_q.push_back(e0 + 97);
    run_to(e0 + 96);
    chk("holdoff_inactive", 64'(active), 64'd0);
    run_to(e0 + 97);
    chk("ev2_active", 64'(active), 64'd1);
    chk("ev2_no_ovf_yet", 64'(overflow), 64'd0);

    // End event 2 with record 1 unacked: sum hits 2000 at e0+108, exit e0+110.
    // Event 2 is lost to overflow, so it never enters the scoreboard.
    run_to(e0 + 100);
    lastShort = 16'd1000;
    run_to(e0 + 109);
    chk("ev2_pre_ovf", 64'(overflow), 64'd0);
    run_to(e0 + 110);
    lastShort = '0;
    chk("ev2_ovf", 64'(overflow), 64'd1);
    chk("ev2_ended", 64'(active), 64'd0);
    check_rec("ovf_keeps_rec1");
    eventAck = 1'b1;
    tick();
    eventAck = 1'b0;
    void'(rec_q.pop_front());
    chk("ack_clears", 64'(eventValid), 64'd0);
    eventAck = 1'b1;
    tick();
    eventAck = 1'b0;
    chk("stray_ack_valid", 64'(eventValid), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Hold onCond: forced end when len==4095 (trigger T, exit T+4096),
    // hold-off to T+4160, retrigger at T+4161.
    run_to(e0 + 200);
    e1 = cyc;
    firstShort = 16'd1000;
    pulse_q.push_back(e1 + 7);
    rec_q.push_back(rec_t'{t: 32'(e1 + 6), len: 16'd4095, pk: SUM_W'(10000)});
    run_to(e1 + 10);
    firstShort = '0;
    run_to(e1 + 7 + 4095);
    chk("long_ev_active", 64'(active), 64'd1);
    run_to(e1 + 7 + 4096);
    chk("long_ev_forced_end", 64'(active), 64'd0);
    check_rec("long_ev_rec");
    eventAck = 1'b1;
    tick();
    eventAck = 1'b0;
    void'(rec_q.pop_front());
    pulse_q.push_back(e1 + 7 + 4161);
    run_to(e1 + 7 + 4161);
    chk("rearm_active", 64'(active), 64'd1);
    run_to(e1 + 7 + 4164);
    initDone = 1'b0;
    tick();
    chk("abort_inactive", 64'(active), 64'd0);
    repeat (10) tick();
    chk("abort_no_rec", 64'(eventValid), 64'd0);

    // Re-enable: IDLE->ARMED next edge, trigger the edge after. Then reset mid-event.
    k = cyc;
    initDone = 1'b1;
    pulse_q.push_back(k + 2);
    repeat (5) tick();
    chk("pre_rst_active", 64'(active), 64'd1);
    chk("pre_rst_ovf", 64'(overflow), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_outputs_zero("midrun_rst");
    chk("rst_short", 64'(dut.shortSum), 64'd0);
    firstShort = '0; lastShort = '0; firstLong = '0; lastLong = '0;
    @(posedge clock); #1;
    reset = 1'b1; cyc = 0;
    tick();
    chk("post_rst_short", 64'(dut.shortSum), 64'd0);
    chk("post_rst_long", 64'(dut.longSum), 64'd0);
    chk("post_rst_valid", 64'(eventValid), 64'd0);
    chk("pulses_consumed", 64'(pulse_q.size()), 64'd0);
    chk("recs_consumed", 64'(rec_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
